// File: rtl/line_buffer_ctrl_xppc.sv
// Sequencer for the Xppc line-buffer delay-line chain: tracks column/row, drives the shared
// delay-line enable, emits a BRAM-aligned output stream and injects end-of-frame flush lines.
module line_buffer_ctrl_xppc #(
  parameter int unsigned MAX_SAMPLES_PER_CLOCK = 4,
  parameter int unsigned PIXELS_PER_LINE       = 64,
  parameter int unsigned LINES_PER_FRAME       = 48,
  parameter int unsigned WINDOW_SIZE           = 5,
  localparam int unsigned HALF  = (WINDOW_SIZE - 1) / 2,
  localparam int unsigned WPL   = PIXELS_PER_LINE / MAX_SAMPLES_PER_CLOCK,
  localparam int unsigned COL_W = (WPL > 1) ? $clog2(WPL) : 1,
  localparam int unsigned ROW_W = $clog2(LINES_PER_FRAME + HALF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tuser,
  input  logic             s_tlast,
  input  logic             m_tready,
  output logic             line_ce,
  output logic             line_tlast,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic             m_tvalid,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic             flush_act,
  output logic             err_sync
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic             NO_FILL        = (HALF == 0);
  localparam logic [COL_W-1:0] COL_LAST       = COL_W'(WPL - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST  = ROW_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [ROW_W-1:0] ROW_FRAME_LAST = ROW_W'(LINES_PER_FRAME - 1);
  localparam logic [ROW_W-1:0] ROW_FLUSH_LAST = ROW_W'(LINES_PER_FRAME + HALF - 1);

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tuser_q, m_tuser_d;
  logic             m_tlast_q, m_tlast_d;
  logic             first_q, first_d;
  logic             err_q, err_d;

  logic             accept, sof, restart, col_end, end_line, out_word, out_load;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;

  always_comb begin
    s_tready = 1'b0;
    line_ce  = 1'b0;
    unique case (state_q)
      ST_IDLE:  s_tready = 1'b1;
      ST_FILL:  s_tready = 1'b1;
      ST_RUN:   s_tready = m_tready;
      default:  s_tready = 1'b0;
    endcase

    accept  = s_tvalid & s_tready;
    sof     = accept & s_tuser;
    restart = sof & ((state_q == ST_FILL) | (state_q == ST_RUN));

    unique case (state_q)
      ST_IDLE:  line_ce = sof;
      ST_FILL:  line_ce = accept;
      ST_RUN:   line_ce = accept;
      default:  line_ce = m_tready;
    endcase

    // A start-of-frame word is always position (0,0), whatever the counters held.
    eff_col  = sof ? '0 : col_q;
    eff_row  = sof ? '0 : row_q;
    col_end  = (eff_col == COL_LAST);
    end_line = line_ce & (col_end | (accept & s_tlast));

    out_word = (line_ce & ~sof & ((state_q == ST_RUN) | (state_q == ST_FLUSH)))
             | (NO_FILL & sof);

    err_d = (line_ce & accept & (s_tlast ^ col_end)) | restart;

    col_d = col_q;
    row_d = row_q;
    if (line_ce) begin
      if (end_line) begin
        col_d = '0;
        row_d = eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end

    state_d = state_q;
    if (sof) begin
      state_d = (NO_FILL | (end_line & (eff_row == ROW_FILL_LAST))) ? ST_RUN : ST_FILL;
    end else begin
      unique case (state_q)
        ST_FILL: if (end_line && row_q == ROW_FILL_LAST) state_d = ST_RUN;
        ST_RUN: begin
          if (end_line && row_q == ROW_FRAME_LAST) state_d = NO_FILL ? ST_IDLE : ST_FLUSH;
        end
        ST_FLUSH: if (end_line && row_q == ROW_FLUSH_LAST) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
    if (state_d == ST_IDLE) begin
      col_d = '0;
      row_d = '0;
    end

    first_d = sof ? ~NO_FILL : (out_word ? 1'b0 : first_q);

    // Output register holds while the downstream stalls a valid word.
    out_load   = m_tready | ~m_tvalid_q;
    m_tvalid_d = out_load ? out_word : m_tvalid_q;
    m_tuser_d  = out_load ? (out_word & (first_q | sof)) : m_tuser_q;
    m_tlast_d  = out_load ? (out_word & end_line) : m_tlast_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      first_q    <= first_d;
      err_q      <= err_d;
    end
  end

  assign line_tlast = end_line;
  assign col_idx    = eff_col;
  assign row_idx    = eff_row;
  assign m_tvalid   = m_tvalid_q;
  assign m_tuser    = m_tuser_q;
  assign m_tlast    = m_tlast_q;
  assign flush_act  = (state_q == ST_FLUSH);
  assign err_sync   = err_q;

endmodule

// File: tb/tb_line_buffer_ctrl_xppc.sv
// Directed bench for line_buffer_ctrl_xppc: 16 words/line, 8 lines/frame, window 5 (2 flush lines).
module tb_line_buffer_ctrl_xppc;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid, s_tready, s_tuser, s_tlast, m_tready;
  logic       line_ce, line_tlast, m_tvalid, m_tuser, m_tlast, flush_act, err_sync;
  logic [3:0] col_idx;
  logic [3:0] row_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_cnt, mv_cnt, ml_cnt, mu_cnt, err_cnt, first_mv_ce;
  bit seen_mv;
  bit hold_prev = 1'b0;
  logic prev_v, prev_u, prev_l;

  line_buffer_ctrl_xppc #(
    .MAX_SAMPLES_PER_CLOCK(4),
    .PIXELS_PER_LINE      (64),
    .LINES_PER_FRAME      (8),
    .WINDOW_SIZE          (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tuser   (s_tuser),
    .s_tlast   (s_tlast),
    .m_tready  (m_tready),
    .line_ce   (line_ce),
    .line_tlast(line_tlast),
    .col_idx   (col_idx),
    .row_idx   (row_idx),
    .m_tvalid  (m_tvalid),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .flush_act (flush_act),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic u, input logic l);
    s_tvalid = v;
    s_tuser  = u;
    s_tlast  = l;
  endtask

  task automatic clr();
    ce_cnt = 0; mv_cnt = 0; ml_cnt = 0; mu_cnt = 0; err_cnt = 0;
    first_mv_ce = -1; seen_mv = 1'b0;
  endtask

  // Observers sample on the falling edge, between input updates and active edges.
  always @(negedge clk) begin
    if (hold_prev) begin
      chk("hold_tvalid", m_tvalid, prev_v);
      chk("hold_tuser", m_tuser, prev_u);
      chk("hold_tlast", m_tlast, prev_l);
    end
    hold_prev = m_tvalid & ~m_tready & ~rst;
    prev_v = m_tvalid; prev_u = m_tuser; prev_l = m_tlast;
    if (m_tvalid && !seen_mv) begin
      seen_mv = 1'b1;
      first_mv_ce = ce_cnt;
    end
    if (line_ce) ce_cnt++;
    if (err_sync) err_cnt++;
    if (m_tvalid && m_tready) begin
      mv_cnt++;
      if (m_tlast) ml_cnt++;
      if (m_tuser) mu_cnt++;
    end
  end

  task automatic full_frame(input string tag);
    int g;
    clr();
    m_tready = 1'b1;
    for (int idx = 0; idx < 128; idx++) begin
      drive(1'b1, idx == 0, (idx % 16) == 15);
      #1;
      if (idx == 0) chk({tag, "_ce_sof"}, line_ce, 1);
      if (idx == 31) chk({tag, "_ltlast_r1"}, line_tlast, 1);
      if (idx == 32) chk({tag, "_row_w32"}, row_idx, 2);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk({tag, "_flush_act"}, flush_act, 1);
    chk({tag, "_flush_srdy"}, s_tready, 0);
    g = 0;
    while (flush_act === 1'b1 && g < 100) begin
      g++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_flush_cycles"}, g, 32);
    repeat (2) cyc();
    chk({tag, "_ce_total"}, ce_cnt, 160);
    chk({tag, "_mv_total"}, mv_cnt, 128);
    chk({tag, "_mlast_total"}, ml_cnt, 8);
    chk({tag, "_muser_total"}, mu_cnt, 1);
    chk({tag, "_first_mv"}, first_mv_ce, 33);
    chk({tag, "_err_total"}, err_cnt, 0);
    chk({tag, "_idle_srdy"}, s_tready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, g;
    logic mt, acc;
    rst = 1'b1;
    m_tready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr();
    #2;
    chk("rst_srdy", s_tready, 1);
    chk("rst_ce", line_ce, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_flush", flush_act, 0);
    chk("rst_err", err_sync, 0);
    chk("rst_col", col_idx, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_ltlast", line_tlast, 0);
    cyc();
    rst = 1'b0;

    // Words without start-of-frame while idle are swallowed.
    clr();
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("idle_drop_ce", line_ce, 0);
    chk("idle_drop_srdy", s_tready, 1);
    repeat (3) cyc();
    drive(1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    cyc();
    chk("idle_drop_cecnt", ce_cnt, 0);
    chk("idle_drop_mv", mv_cnt, 0);
    chk("idle_drop_err", err_cnt, 0);

    full_frame("frame1");

    // Backpressure: m_tready toggles every cycle once the window is full.
    clr();
    m_tready = 1'b1;
    mt = 1'b1;
    idx = 0;
    g = 0;
    while (idx < 128 && g < 1000) begin
      g++;
      if (idx >= 32) mt = ~mt;
      m_tready = mt;
      drive(1'b1, idx == 0, (idx % 16) == 15);
      #1;
      if (idx >= 32 && idx < 36) chk("bp_srdy_mirror", s_tready, mt);
      acc = s_tready;
      cyc();
      if (acc) idx++;
    end
    drive(1'b0, 1'b0, 1'b0);
    g = 0;
    do begin
      mt = ~mt;
      m_tready = mt;
      cyc();
      g++;
    end while (flush_act === 1'b1 && g < 300);
    m_tready = 1'b1;
    repeat (3) cyc();
    chk("bp_flush_done", flush_act, 0);
    chk("bp_ce_total", ce_cnt, 160);
    chk("bp_mv_total", mv_cnt, 128);
    chk("bp_mlast_total", ml_cnt, 8);
    chk("bp_muser_total", mu_cnt, 1);
    chk("bp_err_total", err_cnt, 0);

    // Early s_tlast at row 3 col 9.
    clr();
    for (int i = 0; i <= 56; i++) begin
      drive(1'b1, i == 0, (i % 16) == 15);
      cyc();
    end
    drive(1'b1, 1'b0, 1'b1);
    #1;
    chk("early_col", col_idx, 9);
    chk("early_row", row_idx, 3);
    chk("early_ltlast", line_tlast, 1);
    cyc();
    chk("early_err", err_sync, 1);
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("early_next_col", col_idx, 0);
    chk("early_next_row", row_idx, 4);
    cyc();
    chk("early_err_pulse", err_sync, 0);

    // Advance to row 5 col 7, then restart with s_tuser.
    for (int c = 1; c <= 22; c++) begin
      drive(1'b1, 1'b0, c == 15);
      cyc();
    end
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("rs_col", col_idx, 0);
    chk("rs_row", row_idx, 0);
    chk("rs_ce", line_ce, 1);
    cyc();
    chk("rs_err", err_sync, 1);
    clr();
    m_tready = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, (i % 16) == 15);
      #1;
      if (i == 31) chk("rs_fill_srdy", s_tready, 1);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rs_run_srdy", s_tready, 0);
    chk("rs_no_mv", mv_cnt, 0);
    chk("rs_no_mvalid", m_tvalid, 0);
    m_tready = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("rs_first_mvalid", m_tvalid, 1);
    chk("rs_first_muser", m_tuser, 1);

    // Finish the frame, then reset in the middle of the flush.
    for (int i = 33; i < 128; i++) begin
      drive(1'b1, 1'b0, (i % 16) == 15);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) cyc();
    chk("fr_flush_act", flush_act, 1);
    chk("fr_mvalid", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("fr_rst_mvalid", m_tvalid, 0);
    chk("fr_rst_ce", line_ce, 0);
    chk("fr_rst_flush", flush_act, 0);
    chk("fr_rst_srdy", s_tready, 1);
    chk("fr_rst_row", row_idx, 0);
    cyc();
    rst = 1'b0;
    cyc();

    full_frame("frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
